decoder_scan_n: RTL and testbench

- Parametrised, registered successor to the team's combinational 3-to-8 decoder.
- Produces a one-hot select bus from a binary code in DIRECT mode.
- In SCAN mode it autonomously steps the one-hot output through every line, holding each line for a programmable dwell. Used for row/digit multiplexing and round-robin strobes.
- Sits between control logic and row/digit drivers; all outputs come straight from flops (glitch-free).

---
 rtl/decoder_scan_n_if.sv | 26 ++
 rtl/decoder_scan_n.sv | 96 +++++++++
 tb/tb_decoder_scan_n.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_n_if.sv
// Bus between control logic and the one-hot decoder/scanner: code and dwell in,
// select lines and status out.
interface decoder_scan_n_if #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
);
  logic               enable;
  logic               mode;
  logic [SEL_W-1:0]   in;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;
  logic               err;

  modport master (
    output enable, mode, in, dwell,
    input  out, cur_sel, wrap, err
  );

  modport slave (
    input  enable, mode, in, dwell,
    output out, cur_sel, wrap, err
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered binary-to-one-hot decoder with an autonomous scan mode that walks
// every line, holding each for dwell+1 cycles. All outputs are flops.
//
// state    | meaning
// S_IDLE   | disabled: out blanked, scan position and dwell count frozen
// S_DIRECT | out decodes the live binary code
// S_SCAN   | out steps through lines 0..OUT_W-1 autonomously
module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
) (
  input logic             clk,
  input logic             rst,
  decoder_scan_n_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

  // One extra bit so OUT_W == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   NUM_LINES = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(OUT_W - 1);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               code_valid;
  logic [SEL_W-1:0]   next_sel;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] o;
    o = '0;
    for (int i = 0; i < OUT_W; i++) begin
      o[i] = (s == SEL_W'(i));
    end
    return o;
  endfunction

  assign code_valid = ({1'b0, bus.in} < NUM_LINES);
  assign next_sel   = (bus.cur_sel == LAST_SEL) ? '0 : bus.cur_sel + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bus.out     <= '0;
      bus.cur_sel <= '0;
      bus.wrap    <= 1'b0;
      bus.err     <= 1'b0;
      cnt         <= '0;
    end else if (!bus.enable) begin
      state    <= S_IDLE;
      bus.out  <= '0;
      bus.wrap <= 1'b0;
      bus.err  <= 1'b0;
    end else if (!bus.mode) begin
      state    <= S_DIRECT;
      bus.wrap <= 1'b0;
      cnt      <= '0;
      if (code_valid) begin
        bus.out     <= onehot(bus.in);
        bus.cur_sel <= bus.in;
        bus.err     <= 1'b0;
      end else begin
        bus.out <= '0;
        bus.err <= 1'b1;
      end
    end else begin
      state   <= S_SCAN;
      bus.err <= 1'b0;
      case (state)
        S_DIRECT: begin
          bus.out     <= onehot('0);
          bus.cur_sel <= '0;
          bus.wrap    <= 1'b0;
          cnt         <= '0;
        end
        // Resume shows the frozen line first; stepping starts on the next edge.
        S_IDLE: begin
          bus.out  <= onehot(bus.cur_sel);
          bus.wrap <= 1'b0;
        end
        default: begin
          if (cnt >= bus.dwell) begin
            cnt         <= '0;
            bus.cur_sel <= next_sel;
            bus.out     <= onehot(next_sel);
            bus.wrap    <= (bus.cur_sel == LAST_SEL);
          end else begin
            cnt      <= cnt + DWELL_W'(1);
            bus.wrap <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Bench for decoder_scan_n: an 8-line and a 6-line instance share one stimulus
// stream and are checked each cycle against a behavioural model plus literals.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] code = '0;
  logic [7:0] dwell = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan_n_if #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) ifa ();
  decoder_scan_n_if #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) ifb ();

  assign ifa.enable = enable;
  assign ifa.mode   = mode;
  assign ifa.in     = code;
  assign ifa.dwell  = dwell;
  assign ifb.enable = enable;
  assign ifb.mode   = mode;
  assign ifb.in     = code;
  assign ifb.dwell  = dwell;

  decoder_scan_n #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  decoder_scan_n #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // prev: 0 = disabled, 1 = direct, 2 = scan; age = extra cycles spent on the current line.
  typedef struct {
    int line;
    int age;
    int prev;
    int out;
    int wrap;
    int err;
  } mdl_t;

  mdl_t ma, mb;
  bit   mvalid = 1'b0;

  function automatic mdl_t mstep(mdl_t m, int r, int en, int md, int c, int dw, int n);
    mdl_t x;
    x = m;
    if (r != 0) begin
      x = '{0, 0, 0, 0, 0, 0};
    end else if (en == 0) begin
      x.prev = 0; x.out = 0; x.wrap = 0; x.err = 0;
    end else if (md == 0) begin
      x.prev = 1; x.age = 0; x.wrap = 0;
      if (c < n) begin
        x.line = c; x.out = 1 << c; x.err = 0;
      end else begin
        x.out = 0; x.err = 1;
      end
    end else begin
      x.err = 0; x.wrap = 0;
      if (m.prev == 1) begin
        x.line = 0; x.age = 0;
      end else if (m.prev == 2) begin
        if (m.age >= dw) begin
          x.age  = 0;
          x.line = (m.line + 1) % n;
          x.wrap = (m.line == n - 1) ? 1 : 0;
        end else begin
          x.age = m.age + 1;
        end
      end
      x.out  = 1 << x.line;
      x.prev = 2;
    end
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma = mstep(ma, int'(rst), int'(enable), int'(mode), int'(code), int'(dwell), 8);
    mb = mstep(mb, int'(rst), int'(enable), int'(mode), int'(code), int'(dwell), 6);
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("a_out",  int'(ifa.out),     ma.out);
      chk("a_sel",  int'(ifa.cur_sel), ma.line);
      chk("a_wrap", int'(ifa.wrap),    ma.wrap);
      chk("a_err",  int'(ifa.err),     ma.err);
      chk("b_out",  int'(ifb.out),     mb.out);
      chk("b_sel",  int'(ifb.cur_sel), mb.line);
      chk("b_wrap", int'(ifb.wrap),    mb.wrap);
      chk("b_err",  int'(ifb.err),     mb.err);
      chk("a_onehot", int'($countones(ifa.out) <= 1), 1);
    end
  end

  task automatic cyc(input bit r, input bit e, input bit m, input int c, input int d);
    rst    = r;
    enable = e;
    mode   = m;
    code   = 3'(c);
    dwell  = 8'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_out",  int'(ifa.out), 0);
    chk("rst_sel",  int'(ifa.cur_sel), 0);
    chk("rst_wrap", int'(ifa.wrap), 0);
    chk("rst_err",  int'(ifa.err), 0);

    // Direct sweep; the 6-line instance sees 6 and 7 as invalid.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, i, 0);
      chk("dir_out", int'(ifa.out), 1 << i);
      chk("dir_sel", int'(ifa.cur_sel), i);
      chk("dir_err", int'(ifa.err), 0);
      if (i >= 6) begin
        chk("inv_out", int'(ifb.out), 0);
        chk("inv_err", int'(ifb.err), 1);
        chk("inv_sel", int'(ifb.cur_sel), 5);
      end
    end
    cyc(0, 1, 0, 2, 0);
    chk("inv_rec_out", int'(ifb.out), 'h04);
    chk("inv_rec_err", int'(ifb.err), 0);

    // Scan dwell=2 from reset: each line for 3 cycles, wrap on the 25th.
    cyc(1, 1, 1, 0, 2);
    for (int k = 0; k < 27; k++) begin
      cyc(0, 1, 1, 0, 2);
      chk("scan_out", int'(ifa.out), (k >= 24) ? 1 : (1 << (k / 3)));
      chk("scan_wrap", int'(ifa.wrap), (k == 24) ? 1 : 0);
    end

    // dwell=0, freeze at line 5 for 4 cycles, then resume.
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0);
    chk("pre_freeze_sel", int'(ifa.cur_sel), 5);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk("freeze_out", int'(ifa.out), 0);
      chk("freeze_sel", int'(ifa.cur_sel), 5);
    end
    cyc(0, 1, 1, 0, 0);
    chk("resume_out", int'(ifa.out), 'h20);
    cyc(0, 1, 1, 0, 0);
    chk("resume_next", int'(ifa.out), 'h40);

    // Scan at line 3 -> direct 6 -> scan restarts at 0.
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0);
    chk("pre_switch_sel", int'(ifa.cur_sel), 3);
    cyc(0, 1, 0, 6, 0);
    chk("switch_out", int'(ifa.out), 'h40);
    chk("switch_sel", int'(ifa.cur_sel), 6);
    cyc(0, 1, 1, 6, 0);
    chk("back_out", int'(ifa.out), 'h01);
    chk("back_sel", int'(ifa.cur_sel), 0);

    // Reset mid-scan at line 4.
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0);
    chk("pre_rst_sel", int'(ifa.cur_sel), 4);
    cyc(1, 1, 1, 0, 0);
    chk("mid_rst_out", int'(ifa.out), 0);
    chk("mid_rst_sel", int'(ifa.cur_sel), 0);
    chk("mid_rst_wrap", int'(ifa.wrap), 0);
    cyc(0, 1, 1, 0, 0);
    chk("post_rst_out", int'(ifa.out), 'h01);
    cyc(0, 1, 1, 0, 0);
    chk("post_rst_next", int'(ifa.out), 'h02);

    // Live dwell: lowered below the running count advances on the next edge.
    cyc(1, 1, 1, 0, 5);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 5);
    chk("dw_hold", int'(ifa.out), 'h01);
    cyc(0, 1, 1, 0, 1);
    chk("dw_lower", int'(ifa.out), 'h02);
    cyc(0, 1, 1, 0, 1);
    chk("dw_one_a", int'(ifa.out), 'h02);
    cyc(0, 1, 1, 0, 1);
    chk("dw_one_b", int'(ifa.out), 'h04);

    // dwell=0 on the 6-line instance wraps from 5 to 0.
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 0);
    chk("b_wrap_out", int'(ifb.out), 'h01);
    chk("b_wrap_pulse", int'(ifb.wrap), 1);

    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
